// File: rtl/jt12_chacc_if.sv
// -----------------------------------------------------------------------------
// jt12_chacc_if
//   Bundles the operator-side slot stream and the accumulated channel-sample
//   output that connect the channel accumulator to its neighbours.
//
//   Parameters:
//     OUT_W     width of the signed channel sample (10..16)
//   Signals:
//     clk_en    clock enable; all accumulator state advances only when high
//     op_result signed 14-bit operator output for the current slot
//     alg       algorithm of the channel owning the current slot
//     zero      marks slot 0 (channel 0, S1) and resynchronises the slot count
//     ch_sum    signed accumulated channel sample
//     ch_idx    channel number (0..5) of ch_sum
//     ch_valid  one-clock strobe when ch_sum/ch_idx are updated
//   Modports:
//     master    operator side (drives the slot stream, receives samples)
//     slave     accumulator side
// -----------------------------------------------------------------------------
interface jt12_chacc_if #(
  parameter int OUT_W = 14
);
  logic                    clk_en;
  logic signed [13:0]      op_result;
  logic [2:0]              alg;
  logic                    zero;
  logic signed [OUT_W-1:0] ch_sum;
  logic [2:0]              ch_idx;
  logic                    ch_valid;

  modport master (
    output clk_en, op_result, alg, zero,
    input  ch_sum, ch_idx, ch_valid
  );

  modport slave (
    input  clk_en, op_result, alg, zero,
    output ch_sum, ch_idx, ch_valid
  );
endinterface

// File: rtl/jt12_chacc.sv
// -----------------------------------------------------------------------------
// jt12_chacc
//   Channel accumulator behind the FM operator stage. Operator outputs arrive
//   one slot per clk_en in hardware order (24 slots: four groups of six
//   channels, groups ordered S1, S3, S2, S4). For each channel the carrier
//   operators of its algorithm are summed; on the S4 slot the total is
//   converted to OUT_W bits, registered, and strobed out with its channel
//   number.
//
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   jt12_chacc_if.slave (clk_en, op_result, alg, zero in;
//           ch_sum, ch_idx, ch_valid out)
//
//   Configuration:
//     JT12_CHACC_CLIP_EN  defined   -> total saturates to the signed OUT_W range
//                         undefined -> total is truncated to its OUT_W LSBs
// -----------------------------------------------------------------------------
module jt12_chacc #(
  parameter int OUT_W = 14
) (
  input  logic         clk,
  input  logic         rst,
  jt12_chacc_if.slave  bus
);

  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_e;

  localparam logic [4:0] LAST_SLOT = 5'd23;

  // Registered state
  logic [4:0]              slot_q,     slot_d;
  logic signed [15:0]      acc_q [6];
  logic signed [15:0]      acc_d [6];
  logic [5:0]              started_q,  started_d;
  logic signed [OUT_W-1:0] ch_sum_q,   ch_sum_d;
  logic [2:0]              ch_idx_q,   ch_idx_d;
  logic                    ch_valid_q, ch_valid_d;

  // Per-slot decode
  logic [4:0]              slot_eff;
  logic                    resync;
  grp_e                    grp;
  logic [2:0]              chan;
  logic                    carrier;
  logic                    head_started;
  logic signed [15:0]      addend;
  logic signed [15:0]      total;
  logic signed [OUT_W-1:0] sum_conv;

  // zero forces the current slot to 0; arriving anywhere else it means the
  // frame lost alignment, so every channel in progress is abandoned.
  assign slot_eff = bus.zero ? 5'd0 : slot_q;
  assign resync   = bus.zero && (slot_q != 5'd0);

  // Group and channel from the slot. The channel offset is taken modulo 8 on
  // the low three bits, which is exact because the result is always 0..5.
  always_comb begin
    if (slot_eff >= 5'd18) begin
      grp  = GRP_S4;
      chan = slot_eff[2:0] - 3'd2;
    end else if (slot_eff >= 5'd12) begin
      grp  = GRP_S2;
      chan = slot_eff[2:0] - 3'd4;
    end else if (slot_eff >= 5'd6) begin
      grp  = GRP_S3;
      chan = slot_eff[2:0] - 3'd6;
    end else begin
      grp  = GRP_S1;
      chan = slot_eff[2:0];
    end
  end

  // Which operator groups are carriers for each algorithm.
  always_comb begin
    case (bus.alg)
      3'd0, 3'd1, 3'd2, 3'd3: carrier = (grp == GRP_S4);
      3'd4:                   carrier = (grp == GRP_S2) || (grp == GRP_S4);
      3'd5, 3'd6:             carrier = (grp != GRP_S1);
      default:                carrier = 1'b1;
    endcase
  end

  assign addend       = carrier ? {{2{bus.op_result[13]}}, bus.op_result} : 16'sd0;
  assign head_started = started_q[0] & ~resync;
  assign total        = acc_q[0] + addend;

`ifdef JT12_CHACC_CLIP_EN
  localparam int                 SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [15:0] SAT_MAX   = 16'(SAT_MAX_I);
  localparam logic signed [15:0] SAT_MIN   = 16'(-SAT_MAX_I - 1);

  always_comb begin
    if (total > SAT_MAX) begin
      sum_conv = SAT_MAX[OUT_W-1:0];
    end else if (total < SAT_MIN) begin
      sum_conv = SAT_MIN[OUT_W-1:0];
    end else begin
      sum_conv = total[OUT_W-1:0];
    end
  end
`else
  // Plain truncation: two's-complement wrap-around on overflow.
  assign sum_conv = total[OUT_W-1:0];
`endif

  // Next-state logic. The six-entry buffer rotates once per clk_en: entry 0
  // always belongs to the channel of the current slot and its updated value
  // re-enters at entry 5, returning to the head six slots later.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred; blocking '=' is
    // correct here because this is combinational logic.
    slot_d     = slot_q;
    acc_d      = acc_q;
    started_d  = started_q;
    ch_sum_d   = ch_sum_q;
    ch_idx_d   = ch_idx_q;
    ch_valid_d = 1'b0;

    if (bus.clk_en) begin
      slot_d = (slot_eff == LAST_SLOT) ? 5'd0 : slot_eff + 5'd1;

      for (int i = 0; i < 5; i++) begin
        acc_d[i] = acc_q[i+1];
      end
      started_d[4:0] = started_q[5:1] & ~{5{resync}};

      case (grp)
        GRP_S1: begin
          acc_d[5]     = addend;
          started_d[5] = 1'b1;
        end
        GRP_S3, GRP_S2: begin
          acc_d[5]     = total;
          started_d[5] = head_started;
        end
        default: begin
          acc_d[5]     = total;
          started_d[5] = 1'b0;
          // Only channels whose S1 was seen since the last reset/resync
          // produce a sample.
          if (head_started) begin
            ch_sum_d   = sum_conv;
            ch_idx_d   = chan;
            ch_valid_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update
    // together from values sampled before the edge.
    if (rst) begin
      slot_q <= 5'd0;
      // NOTE: the accumulator buffer is reset explicitly; it is only six
      // entries of flops (not a RAM), and a clean start keeps the first
      // samples after reset deterministic.
      for (int i = 0; i < 6; i++) begin
        acc_q[i] <= 16'sd0;
      end
      started_q  <= 6'd0;
      ch_sum_q   <= '0;
      ch_idx_q   <= 3'd0;
      ch_valid_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      for (int i = 0; i < 6; i++) begin
        acc_q[i] <= acc_d[i];
      end
      started_q  <= started_d;
      ch_sum_q   <= ch_sum_d;
      ch_idx_q   <= ch_idx_d;
      ch_valid_q <= ch_valid_d;
    end
  end

  assign bus.ch_sum   = ch_sum_q;
  assign bus.ch_idx   = ch_idx_q;
  assign bus.ch_valid = ch_valid_q;

endmodule

// File: tb/tb_jt12_chacc.sv
// -----------------------------------------------------------------------------
// tb_jt12_chacc
//   Self-checking bench for jt12_chacc (OUT_W = 14). A channel-indexed model
//   of the slot rules predicts the outputs after every clock; a compare
//   process checks the DUT against it on every falling edge. Directed frames
//   pin known sums, clock-enable gaps, resync and reset; random frames cover
//   arbitrary algorithms and operator values.
// -----------------------------------------------------------------------------
module tb_jt12_chacc;

  localparam int OUT_W = 14;

`ifdef JT12_CHACC_CLIP_EN
  localparam int T3_POS = 8191;
  localparam int T3_NEG = -8192;
`else
  localparam int T3_POS = -4;
  localparam int T3_NEG = 0;
`endif

  typedef struct {
    int ch;
    int sum;
  } strobe_t;

  logic clk;
  logic rst;

  jt12_chacc_if #(.OUT_W(OUT_W)) bus ();

  jt12_chacc #(.OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Model state: per channel a running sum and an "S1 seen" flag.
  int m_slot  = 0;
  int m_sum  [6];
  bit m_open [6];
  int exp_sum   = 0;
  int exp_idx   = 0;
  bit exp_valid = 1'b0;

  strobe_t dut_q[$];
  strobe_t exp_q[$];
  strobe_t ref_q[$];

  // Stimulus tables: operator value per slot, algorithm per channel.
  int op_tab [24];
  int alg_ch [6];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int conv(input int x);
`ifdef JT12_CHACC_CLIP_EN
    int hi = (1 << (OUT_W - 1)) - 1;
    int lo = -hi - 1;
    return (x > hi) ? hi : ((x < lo) ? lo : x);
`else
    int m = 1 << OUT_W;
    int r = x & (m - 1);
    if (r >= m / 2) r -= m;
    return r;
`endif
  endfunction

  // opn is the operator number (1..4) of the current group.
  function automatic bit is_carrier(input int a, input int opn);
    if (a <= 3) return opn == 4;
    if (a == 4) return (opn == 2) || (opn == 4);
    if (a <= 6) return opn != 1;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit en, input int op,
                            input int a, input bit z);
    int eff, ch, opn, add, tot;
    if (r) begin
      m_slot = 0;
      for (int i = 0; i < 6; i++) begin
        m_sum[i]  = 0;
        m_open[i] = 1'b0;
      end
      exp_valid = 1'b0;
      exp_sum   = 0;
      exp_idx   = 0;
      return;
    end
    exp_valid = 1'b0;
    if (!en) return;
    eff = z ? 0 : m_slot;
    if (z && m_slot != 0) begin
      for (int i = 0; i < 6; i++) m_open[i] = 1'b0;
    end
    ch = eff % 6;
    case (eff / 6)
      0:       opn = 1;
      1:       opn = 3;
      2:       opn = 2;
      default: opn = 4;
    endcase
    add = is_carrier(a, opn) ? op : 0;
    if (opn == 1) begin
      m_sum[ch]  = add;
      m_open[ch] = 1'b1;
    end else if (opn != 4) begin
      m_sum[ch] += add;
    end else begin
      tot = m_sum[ch] + add;
      if (m_open[ch]) begin
        exp_valid = 1'b1;
        exp_sum   = conv(tot);
        exp_idx   = ch;
        exp_q.push_back('{ch: ch, sum: exp_sum});
      end
      m_open[ch] = 1'b0;
    end
    m_slot = (eff + 1) % 24;
  endtask

  // Compare process: outputs are registered, so they are stable here.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ch_valid", {31'd0, bus.ch_valid}, {31'd0, exp_valid});
      check("ch_sum", $signed(bus.ch_sum), exp_sum);
      check("ch_idx", {29'd0, bus.ch_idx}, exp_idx);
      if (bus.ch_valid === 1'b1) begin
        dut_q.push_back('{ch: int'(bus.ch_idx), sum: int'($signed(bus.ch_sum))});
      end
    end
  end

  // One clock: drive after the falling edge, update the model after the
  // rising edge.
  task automatic step(input bit r, input bit en, input int op, input int a,
                      input bit z);
    @(negedge clk);
    rst           = r;
    bus.clk_en    = en;
    bus.op_result = 14'(op);
    bus.alg       = 3'(a);
    bus.zero      = z;
    @(posedge clk);
    #1;
    model_step(r, en, op, a, z);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, int'($urandom_range(0, 16383)) - 8192,
         int'($urandom_range(0, 7)), 1'b0);
  endtask

  task automatic run_slots(input int n);
    int s;
    for (int k = 0; k < n; k++) begin
      s = m_slot;
      step(1'b0, 1'b1, op_tab[s], alg_ch[s % 6], s == 0);
    end
  endtask

  task automatic fill_random();
    for (int s = 0; s < 24; s++) op_tab[s] = int'($urandom_range(0, 16383)) - 8192;
    for (int c = 0; c < 6; c++) alg_ch[c] = int'($urandom_range(0, 7));
  endtask

  task automatic clear_q();
    dut_q.delete();
    exp_q.delete();
  endtask

  task automatic run_to_slot(input int target);
    for (int k = 0; k < 24 && m_slot != target; k++) run_slots(1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.clk_en    = 1'b0;
    bus.op_result = '0;
    bus.alg       = '0;
    bus.zero      = 1'b0;
    fill_random();

    // Reset, with clk_en both low and high.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk_on = 1'b1;
    step(1'b1, 1'b1, 0, 0, 1'b1);
    step(1'b1, 1'b1, 0, 0, 1'b0);
    check("rst_sum", $signed(bus.ch_sum), 0);
    check("rst_valid", {31'd0, bus.ch_valid}, 0);

    // 1. All-carrier sum on channel 2; first strobe is channel 0 at slot 18.
    alg_ch[2] = 7;
    op_tab[2] = 100; op_tab[8] = 200; op_tab[14] = 300; op_tab[20] = 400;
    clear_q();
    run_slots(18);
    check("first_strobe_early", {31'd0, bus.ch_valid}, 0);
    run_slots(1);
    check("first_strobe_valid", {31'd0, bus.ch_valid}, 1);
    check("first_strobe_idx", {29'd0, bus.ch_idx}, 0);
    run_slots(5);
    idle();
    check("t1_count", dut_q.size(), 6);
    if (dut_q.size() == 6) begin
      check("t1_idx", dut_q[2].ch, 2);
      check("t1_sum", dut_q[2].sum, 1000);
    end
    if (exp_q.size() == 6) check("t1_model_sum", exp_q[2].sum, 1000);

    // 2. Single carrier (alg 0), then alg 4 with S2 and S4.
    alg_ch[0] = 0;
    op_tab[0] = 1000; op_tab[6] = 1000; op_tab[12] = 1000; op_tab[18] = -50;
    clear_q();
    run_slots(24);
    idle();
    if (dut_q.size() == 6) check("t2a_sum", dut_q[0].sum, -50);
    else check("t2a_count", dut_q.size(), 6);
    alg_ch[0] = 4;
    op_tab[12] = 300;
    clear_q();
    run_slots(24);
    idle();
    if (dut_q.size() == 6) check("t2b_sum", dut_q[0].sum, 250);
    else check("t2b_count", dut_q.size(), 6);

    // 3. Output conversion at the extremes, channel 1.
    alg_ch[1] = 7;
    op_tab[1] = 8191; op_tab[7] = 8191; op_tab[13] = 8191; op_tab[19] = 8191;
    clear_q();
    run_slots(24);
    idle();
    if (dut_q.size() == 6) check("t3_pos", dut_q[1].sum, T3_POS);
    else check("t3_pos_count", dut_q.size(), 6);
    if (exp_q.size() == 6) check("t3_model_pos", exp_q[1].sum, T3_POS);
    op_tab[1] = -8192; op_tab[7] = -8192; op_tab[13] = -8192; op_tab[19] = -8192;
    clear_q();
    run_slots(24);
    idle();
    if (dut_q.size() == 6) check("t3_neg", dut_q[1].sum, T3_NEG);
    else check("t3_neg_count", dut_q.size(), 6);

    // 4. clk_en gap of 5 clocks mid-frame gives the same samples.
    fill_random();
    clear_q();
    run_slots(24);
    idle();
    ref_q = exp_q;
    clear_q();
    run_slots(10);
    for (int k = 0; k < 5; k++) idle();
    run_slots(14);
    idle();
    check("t4_count", dut_q.size(), 6);
    if (dut_q.size() == 6 && ref_q.size() == 6) begin
      for (int i = 0; i < 6; i++) check("t4_sum", dut_q[i].sum, ref_q[i].sum);
    end

    // 5a. zero at slot 10: nothing until channel 0's S4, 18 slots later.
    run_to_slot(10);
    clear_q();
    step(1'b0, 1'b1, op_tab[0], alg_ch[0], 1'b1);
    run_slots(17);
    check("t5a_quiet", dut_q.size() + int'(bus.ch_valid), 0);
    run_slots(1);
    check("t5a_valid", {31'd0, bus.ch_valid}, 1);
    check("t5a_idx", {29'd0, bus.ch_idx}, 0);

    // 5b. rst pulsed at slot 10.
    run_to_slot(10);
    step(1'b1, 1'b1, op_tab[10], alg_ch[4], 1'b0);
    check("t5b_rst_sum", $signed(bus.ch_sum), 0);
    clear_q();
    run_slots(18);
    check("t5b_quiet", dut_q.size() + int'(bus.ch_valid), 0);
    run_slots(1);
    check("t5b_valid", {31'd0, bus.ch_valid}, 1);
    check("t5b_idx", {29'd0, bus.ch_idx}, 0);

    // 6. Three random frames with occasional clk_en gaps.
    run_to_slot(0);
    idle();
    clear_q();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      for (int s = 0; s < 24; s++) begin
        if ($urandom_range(0, 7) == 0) idle();
        run_slots(1);
      end
    end
    idle();
    check("t6_count", dut_q.size(), 18);
    if (dut_q.size() == 18) begin
      for (int i = 0; i < 18; i++) check("t6_idx_seq", dut_q[i].ch, i % 6);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
